// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: channel FSM state codes and
// the latency-counter width helper.
package mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_READ_BUSY  = 2'd1;
  localparam state_t ST_WRITE_BUSY = 2'd2;
  localparam state_t ST_RESPOND    = 2'd3;

  // Counter holds at most LATENCY-1, so clog2(max+1) bits is always enough.
  function automatic int cnt_width(input int read_latency, input int write_latency);
    int max_lat;
    max_lat = (read_latency > write_latency) ? read_latency : write_latency;
    return $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/mem_responder_channel.sv
// One request channel: accepts a read or write, counts out its latency, and
// exports the write commit and captured address to the array owner.
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and valid is high (read takes priority over write). Ready is high for exactly
// one cycle, LATENCY edges after acceptance; the initiator drops valid on the
// edge it samples ready, and a valid seen again in IDLE is a new request.
module mem_responder_channel
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic [DATA_BITS-1:0] array_rdata,
  output state_t               state,
  output logic                 is_read,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 commit,
  output logic [ADDR_BITS-1:0] cap_addr,
  output logic [DATA_BITS-1:0] cap_data
);

  localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY);

  logic [CNT_W-1:0] cnt;

  assign commit = (state == ST_WRITE_BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      is_read   <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
      read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read_valid) begin
            cap_addr <= read_address;
            cnt      <= CNT_W'(READ_LATENCY - 1);
            is_read  <= 1'b1;
            state    <= ST_READ_BUSY;
          end else if (write_valid) begin
            cap_addr <= write_address;
            cap_data <= write_data;
            cnt      <= CNT_W'(WRITE_LATENCY - 1);
            is_read  <= 1'b0;
            state    <= ST_WRITE_BUSY;
          end
        end
        ST_READ_BUSY: begin
          // array_rdata is the pre-commit value, giving read-old semantics.
          if (cnt == '0) begin
            read_data <= array_rdata;
            state     <= ST_RESPOND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WRITE_BUSY: begin
          if (cnt == '0) state <= ST_RESPOND;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          read_data <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint: word array with host preload/dump port and
// NUM_CHANNELS independent latency-modelled read/write channels.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 1,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   host_write_en,
  input  logic [ADDR_BITS-1:0]                   host_addr,
  input  logic [DATA_BITS-1:0]                   host_wdata,
  output logic [DATA_BITS-1:0]                   host_rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t                  ch_state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_is_read;
  logic [NUM_CHANNELS-1:0] ch_commit;
  logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    ch_data  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    ch_rdata [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_responder_channel #(
      .ADDR_BITS    (ADDR_BITS),
      .DATA_BITS    (DATA_BITS),
      .READ_LATENCY (READ_LATENCY),
      .WRITE_LATENCY(WRITE_LATENCY)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .read_valid   (mem_read_valid[c]),
      .read_address (mem_read_address[c]),
      .write_valid  (mem_write_valid[c]),
      .write_address(mem_write_address[c]),
      .write_data   (mem_write_data[c]),
      .array_rdata  (ch_rdata[c]),
      .state        (ch_state[c]),
      .is_read      (ch_is_read[c]),
      .read_data    (mem_read_data[c]),
      .commit       (ch_commit[c]),
      .cap_addr     (ch_addr[c]),
      .cap_data     (ch_data[c])
    );

    assign ch_rdata[c]        = mem[ch_addr[c]];
    assign mem_read_ready[c]  = (ch_state[c] == ST_RESPOND) &&  ch_is_read[c];
    assign mem_write_ready[c] = (ch_state[c] == ST_RESPOND) && !ch_is_read[c];
  end

  assign host_rdata = mem[host_addr];

  // Array is never reset. Later assignments win: host first, then channels
  // in ascending index so the highest channel owns a same-edge collision.
  always_ff @(posedge clk) begin
    if (host_write_en) mem[host_addr] <= host_wdata;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (WRITE_ENABLE != 0 && ch_commit[c]) mem[ch_addr[c]] <= ch_data[c];
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the per-channel mem_read/mem_write valid/ready interface driven by the memory controller.
- Holds a word-addressed data array and serves one outstanding request per channel, with configurable read/write latency.
- Used as the data/program memory model behind the controller; also has a host port for preload and dump.

Parameters:
ADDR_BITS, 8, address width; array depth = 2**ADDR_BITS words
DATA_BITS, 16, word width
NUM_CHANNELS, 1, independent request channels
READ_LATENCY, 2, edges from request acceptance to read ready (>=1)
WRITE_LATENCY, 2, edges from request acceptance to write ready (>=1)
WRITE_ENABLE, 1, 0 = writes acknowledged but array unchanged (program memory)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
mem_read_valid  in  NUM_CHANNELS  per-channel read request
mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address
mem_read_ready  out  NUM_CHANNELS  one-cycle read-complete pulse
mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data, valid while ready high
mem_write_valid  in  NUM_CHANNELS  per-channel write request
mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address
mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data
mem_write_ready  out  NUM_CHANNELS  one-cycle write-complete pulse
host_write_en  in  1  preload write strobe
host_addr  in  ADDR_BITS  preload/dump address
host_wdata  in  DATA_BITS  preload data
host_rdata  out  DATA_BITS  array[host_addr], combinational

Behaviour:
- Reset: asynchronous, active-low. While reset=0, all mem_read_ready, mem_write_ready and mem_read_data are 0, and every channel FSM is in IDLE. Array contents are NOT cleared. Reset mid-operation abandons the in-flight request with no array update and no ready pulse.
- Per-channel FSM states: IDLE, READ_BUSY, WRITE_BUSY, RESPOND.
- IDLE:
  - read_valid=1: capture address, load counter = READ_LATENCY-1, go to READ_BUSY.
  - else write_valid=1: capture address and data, load counter = WRITE_LATENCY-1, go to WRITE_BUSY.
  - Both valid: read is served first; write stays pending and is accepted on a later IDLE cycle.
- BUSY states: decrement the counter each edge. When the counter is 0:
  - read: drive ready=1 and data = array[captured addr] at that edge, then go to RESPOND.
  - write: drive ready=1; if WRITE_ENABLE, write array[captured addr] at that edge; go to RESPOND.
  - Net timing: ready rises exactly LATENCY edges after the acceptance edge.
- RESPOND: clear ready; mem_read_data returns to 0; go to IDLE.
  - Ready is high for exactly one cycle, and the initiator drops valid on the edge it samples ready.
  - A valid still high in IDLE is a new request; there is no double-accept of the completed one.
- Inputs are captured only at acceptance. Address/data changes while busy are ignored.
- Read value is the array state before writes committed on the same edge (read-old).
- Same-edge write collisions to one address: the highest-index channel wins, and any channel wins over the host port.
- host_write_en writes the array on the edge regardless of WRITE_ENABLE.
- Channels are fully independent; there is no arbitration latency.

Decomposition:
- Shared package mem_pkg: FSM state enum (2-bit) and latency-counter width constant (clog2 of the max latency + 1).
- Sub-module mem_responder_channel, one generate instance per channel:
  - contains the FSM, counter and capture registers;
  - exports a commit strobe, address and data to the top.
- The top owns the array and the write-priority merge.

Test Plan:
- Preload array[0x10]=0xBEEF via host; ch0 read 0x10 (READ_LATENCY=2) -> mem_read_ready high exactly 2 edges after acceptance, for 1 cycle, with data 0xBEEF; data 0 the next cycle.
- ch0 write 0x20=0x1234, then read 0x20 -> write_ready 1-cycle pulse after WRITE_LATENCY edges; read returns 0x1234; host_rdata at 0x20 = 0x1234.
- WRITE_ENABLE=0: preload 0x05=0x00AA; write 0x05=0xFFFF -> write_ready still pulses; subsequent read returns 0x00AA.
- NUM_CHANNELS=2:
  - same-edge commit to 0x30, ch0=0x1111 and ch1=0x2222 -> array[0x30]=0x2222;
  - concurrent reads of different addresses both complete with independent timing.
- ch0 read and write valid together -> read completes first; write accepted the cycle after RESPOND and completes WRITE_LATENCY edges later.
- Drive reset low one cycle after accepting a read of 0x10 -> ready/data go 0 immediately with no pulse; after release a new read of 0x10 still returns 0xBEEF.
